// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared types and default timing constants for the input conditioner.
// Revision : 1.0
// ============================================================================
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } button_state_t;

    localparam int DEBOUNCE_DEFAULT = 50000;
    localparam int HOLD_DEFAULT     = 50000000;

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Purpose  : 1-bit 2-flop synchronizer followed by a consecutive-mismatch debouncer.
// Revision : 1.0
// ============================================================================
module debouncer
    import io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic update
);

    localparam int                 c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_level;
    logic               w_mismatch;

    // Synchronizer resets to the pin's idle level so reset reads as "inactive".
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= IDLE_LEVEL;
            r_sync <= IDLE_LEVEL;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    assign w_level    = r_sync ^ IDLE_LEVEL;
    assign w_mismatch = (w_level != stable);
    assign update     = w_mismatch && (r_cnt == c_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (!w_mismatch || update) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (update) begin
                stable <= ~stable;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Debounced switches/button with change pulse and short/long press detect.
// Revision : 1.0
// ============================================================================
module input_conditioner
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_DEFAULT,
    parameter int SW_WIDTH        = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                key_n,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [SW_WIDTH-1:0] switch,
    output logic                sw_changed,
    output logic                pressed,
    output logic                short_press,
    output logic                long_press
);

    localparam int                  c_hold_w    = $clog2(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    logic [SW_WIDTH-1:0] w_sw_update;
    logic                w_key_update;
    logic                w_key_rise;
    button_state_t       r_state;
    button_state_t       w_next_state;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                w_short;
    logic                w_long;

    generate
        for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
            debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (1'b0)
            ) u_sw_deb (
                .clock   (clock),
                .reset_n (reset_n),
                .raw     (sw_raw[i]),
                .stable  (switch[i]),
                .update  (w_sw_update[i])
            );
        end
    endgenerate

    // Button idles high, so its debouncer inverts after synchronization.
    debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (1'b1)
    ) u_key_deb (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (key_n),
        .stable  (pressed),
        .update  (w_key_update)
    );

    assign w_key_rise = w_key_update && !pressed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_key_rise) begin
                    w_next_state = PRESS;
                end
            end
            PRESS: begin
                if (!pressed) begin
                    w_next_state = w_key_rise ? PRESS : IDLE;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_next_state = HELD;
                end
            end
            HELD: begin
                if (!pressed) begin
                    w_next_state = w_key_rise ? PRESS : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_short = (r_state == PRESS) && !pressed;
        w_long  = (r_state == PRESS) && pressed && (r_hold_cnt == c_hold_last);
    end

    // Counter parks at its last value once the long press has been reported.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt  <= '0;
            sw_changed  <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            if ((w_next_state == PRESS) && (r_state != PRESS || !pressed)) begin
                r_hold_cnt <= '0;
            end else if ((r_state == PRESS) && (r_hold_cnt != c_hold_last)) begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
            sw_changed  <= |w_sw_update;
            short_press <= w_short;
            long_press  <= w_long;
        end
    end

endmodule
`default_nettype wire
